// File: rtl/stream_unpacker_pkg.sv
// Shared types and constants for the 32-bit to 24-bit pixel stream unpacker.
// Four 24-bit pixels travel in three 32-bit words, least significant byte first.
package stream_unpacker_pkg;

  localparam logic [1:0] S_W0    = 2'd0;
  localparam logic [1:0] S_W1    = 2'd1;
  localparam logic [1:0] S_W2    = 2'd2;
  localparam logic [1:0] S_EXTRA = 2'd3;

  localparam int PIX_PER_GRP   = 4;
  localparam int WORDS_PER_GRP = 3;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } pixel_t;

endpackage

// File: rtl/stream_unpacker_out.sv
// One-deep valid/ready holding register for unpacked pixels.
// Holds pixel, sof and eol steady while the consumer stalls.
module pixel_out_reg
  import stream_unpacker_pkg::*;
(
  input  logic   aclk,
  input  logic   areset,
  input  logic   load_valid,
  input  pixel_t load_pix,
  input  logic   load_sof,
  input  logic   load_eol,
  output logic   can_load,
  output logic   valid,
  output pixel_t pix,
  output logic   sof,
  output logic   eol,
  input  logic   ready
);

  assign can_load = !valid || ready;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      valid <= 1'b0;
      pix   <= '0;
      sof   <= 1'b0;
      eol   <= 1'b0;
    end else if (can_load) begin
      valid <= load_valid;
      if (load_valid) begin
        pix <= load_pix;
        sof <= load_sof;
        eol <= load_eol;
      end
    end
  end

endmodule

// File: rtl/stream_unpacker.sv
// Unpacks 3-word groups into 4 pixels with sof/eol and a sticky framing error.
// Define LINE_LEN_CHECK_EN to also flag lines whose length is not IMG_WIDTH.
module stream_unpacker
  import stream_unpacker_pkg::*;
#(
  parameter int IMG_WIDTH = 640,
  parameter int CNT_W     = 10
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic [31:0] in_stream_tdata,
  input  logic [3:0]  in_stream_tkeep,
  input  logic        in_stream_tlast,
  input  logic        in_stream_tuser,
  input  logic        in_stream_tvalid,
  output logic        in_stream_tready,
  output logic [7:0]  r,
  output logic [7:0]  g,
  output logic [7:0]  b,
  output logic        sof,
  output logic        eol,
  output logic        valid,
  input  logic        ready,
  input  logic        err_clr,
  output logic        err
);

  if ((IMG_WIDTH / PIX_PER_GRP) * WORDS_PER_GRP * 4
      != IMG_WIDTH * 3) begin : g_bad_width
    $error("IMG_WIDTH must be a multiple of 4");
  end
  if ((2 ** CNT_W) <= IMG_WIDTH) begin : g_bad_cnt
    $error("CNT_W too narrow for IMG_WIDTH");
  end

  logic [1:0]  state;
  logic [1:0]  state_nxt;
  logic [15:0] res;
  logic [15:0] res_nxt;
  logic [23:0] p3;
  logic        p3_eol;
  logic        can_load;
  logic        accept;
  logic        w0_eff;
  logic        ld_valid;
  pixel_t      ld_pix;
  logic        ld_sof;
  logic        ld_eol;
  logic        frm_err;
  logic        len_err;
  pixel_t      out_pix;
  logic        unused_keep;

  assign unused_keep = ^in_stream_tkeep;

  assign in_stream_tready = can_load && (state != S_EXTRA) && !areset;
  assign accept = in_stream_tvalid && in_stream_tready;
  // tuser resynchronises: the word is always decoded as the group's first
  assign w0_eff = (state == S_W0) || in_stream_tuser;

  always_comb begin
    state_nxt = state;
    res_nxt   = res;
    ld_valid  = 1'b0;
    ld_pix    = '0;
    ld_sof    = 1'b0;
    ld_eol    = 1'b0;
    frm_err   = 1'b0;
    if (state == S_EXTRA) begin
      if (can_load) begin
        ld_valid  = 1'b1;
        ld_pix    = p3;
        ld_eol    = p3_eol;
        state_nxt = S_W0;
      end
    end else if (accept) begin
      ld_valid = 1'b1;
      ld_eol   = in_stream_tlast;
      unique case (1'b1)
        w0_eff: begin
          ld_pix    = in_stream_tdata[23:0];
          ld_sof    = in_stream_tuser;
          res_nxt   = {8'h00, in_stream_tdata[31:24]};
          state_nxt = S_W1;
          frm_err   = in_stream_tuser && (state != S_W0);
        end
        (!in_stream_tuser && state == S_W1): begin
          ld_pix    = {in_stream_tdata[15:0], res[7:0]};
          res_nxt   = in_stream_tdata[31:16];
          state_nxt = S_W2;
        end
        default: begin
          ld_pix    = {in_stream_tdata[7:0], res};
          ld_eol    = 1'b0;
          res_nxt   = '0;
          state_nxt = S_EXTRA;
        end
      endcase
      if (in_stream_tlast && state_nxt != S_EXTRA) begin
        frm_err   = 1'b1;
        res_nxt   = '0;
        state_nxt = S_W0;
      end
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state  <= S_W0;
      res    <= '0;
      p3     <= '0;
      p3_eol <= 1'b0;
    end else begin
      state <= state_nxt;
      res   <= res_nxt;
      if (accept && state_nxt == S_EXTRA) begin
        p3     <= in_stream_tdata[31:8];
        p3_eol <= in_stream_tlast;
      end
    end
  end

`ifdef LINE_LEN_CHECK_EN
  localparam logic [CNT_W-1:0] LAST = CNT_W'(IMG_WIDTH - 1);
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] idx;
  logic             hs;

  assign hs  = valid && ready;
  assign idx = sof ? '0 : cnt;
  assign len_err = hs && ((eol && idx != LAST) || (!eol && idx == LAST));

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      cnt <= '0;
    end else if (hs) begin
      cnt <= (eol || idx == LAST) ? '0 : idx + 1'b1;
    end
  end
`else
  assign len_err = 1'b0;
`endif

  // a new error wins over a simultaneous clear
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      err <= 1'b0;
    end else begin
      err <= (err && !err_clr) || frm_err || len_err;
    end
  end

  pixel_out_reg u_out (
    .aclk       (aclk),
    .areset     (areset),
    .load_valid (ld_valid),
    .load_pix   (ld_pix),
    .load_sof   (ld_sof),
    .load_eol   (ld_eol),
    .can_load   (can_load),
    .valid      (valid),
    .pix        (out_pix),
    .sof        (sof),
    .eol        (eol),
    .ready      (ready)
  );

  assign r = out_pix.r;
  assign g = out_pix.g;
  assign b = out_pix.b;

endmodule
